// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared FSM encoding for the UART transmit arbiter
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin picker, first req after rr_ptr wins
module uart_tx_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest slot back to rr_ptr+1 so the nearest asserted slot is written last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locking sequencer sharing one UART transmitter
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 trmt,
  output logic [7:0]           tx_data,
  input  logic                 tx_done
);

  state_e               state_q, state_d;
  logic                 trmt_q, trmt_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 locked_q, locked_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic                 win_valid;
  logic [IDX_W-1:0]     win_idx;
  logic [7:0]           win_data;
  logic [NUM_REQ-1:0]   win_onehot;
  logic                 do_issue;

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .index  (pick_idx)
  );

  // While a packet is open only its owner may be chosen, and only once it presents a byte.
  always_comb begin
    win_valid  = locked_q ? req[owner_q] : pick_valid;
    win_idx    = locked_q ? owner_q : pick_idx;
    win_data   = req_data[{win_idx, 3'b000} +: 8];
    win_onehot = NUM_REQ'(1) << win_idx;
  end

  always_comb begin
    state_d   = state_q;
    trmt_d    = 1'b0;
    ack_d     = '0;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    locked_d  = locked_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    do_issue  = 1'b0;

    case (state_q)
      ST_IDLE: do_issue = win_valid;
      // tx_done may still hold the previous byte's stale 1 here, so it is not looked at.
      ST_ARM:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx_done) begin
          if (win_valid) begin
            do_issue = 1'b1;
          end else begin
            state_d = ST_IDLE;
            if (!locked_q) grant_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_issue) begin
      state_d   = ST_ARM;
      trmt_d    = 1'b1;
      tx_data_d = win_data;
      ack_d     = win_onehot;
      grant_d   = win_onehot;
      owner_d   = win_idx;
      rr_ptr_d  = win_idx;
      locked_d  = ~req_last[win_idx];
    end

    busy_d = (state_d != ST_IDLE) || locked_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      trmt_q    <= 1'b0;
      tx_data_q <= 8'h00;
      ack_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
      owner_q   <= '0;
      rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q   <= state_d;
      trmt_q    <= trmt_d;
      tx_data_q <= tx_data_d;
      ack_q     <= ack_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      locked_q  <= locked_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign trmt    = trmt_q;
  assign tx_data = tx_data_q;
  assign ack     = ack_q;
  assign grant   = grant_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a behavioural UART
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int FRAME   = 20;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       b2b;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   ack;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 trmt;
  logic [7:0]           tx_data;
  logic                 tx_done;

  exp_t       exp_q[$];
  logic [8:0] src_q[NUM_REQ][$];

  int n_total = 0;
  int n_bad   = 0;
  int n_trmt  = 0;
  int n_ack   = 0;
  int cnt     = 0;
  int done_age = 0;
  logic clr_pend;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .ack      (ack),
    .grant    (grant),
    .busy     (busy),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic push_src(input int id, input logic [7:0] d, input logic last);
    src_q[id].push_back({last, d});
  endtask

  task automatic expect_byte(input int id, input logic [7:0] d, input logic b2b);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    e.b2b  = b2b;
    exp_q.push_back(e);
  endtask

  task automatic wait_trmt(input int target, input string tag);
    int k;
    k = 0;
    while (n_trmt < target && k < 2000) begin
      @(negedge clk); #1;
      k++;
    end
    chk(tag, 32'(n_trmt >= target), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    int pend;
    k = 0;
    pend = 1;
    while (pend != 0 && k < 3000) begin
      @(negedge clk); #1;
      k++;
      pend = exp_q.size() + (busy ? 1 : 0);
      for (int i = 0; i < NUM_REQ; i++) pend += src_q[i].size();
    end
    chk(tag, 32'(pend), 32'd0);
  endtask

  // Monitor, UART model and requester drivers share one negedge process so their order is fixed.
  initial begin
    exp_t e;
    req = '0; req_data = '0; req_last = '0;
    tx_done = 1'b0; clr_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_done = 1'b0; cnt = 0; clr_pend = 1'b0; done_age = 0;
        req = '0; req_data = '0; req_last = '0;
      end else begin
        if (trmt) begin
          n_trmt++;
          if (exp_q.size() == 0) begin
            chk("extra_trmt", 32'(n_trmt), 32'(n_trmt - 1));
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", 32'(tx_data), 32'(e.data));
            chk("grant", 32'(grant), 32'(1) << e.id);
            chk("ack", 32'(ack), 32'(1) << e.id);
            if (e.b2b) chk("b2b_gap", 32'(done_age), 32'd1);
          end
        end
        if (|ack) n_ack++;

        if (clr_pend) begin
          tx_done = 1'b0; cnt = FRAME; clr_pend = 1'b0;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) tx_done = 1'b1;
        end
        if (trmt) clr_pend = 1'b1;
        done_age = tx_done ? done_age + 1 : 0;

        for (int i = 0; i < NUM_REQ; i++) begin
          if (ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
          if (src_q[i].size() > 0) begin
            req[i] = 1'b1;
            req_data[i*8 +: 8] = src_q[i][0][7:0];
            req_last[i] = src_q[i][0][8];
          end else begin
            req[i] = 1'b0;
            req_data[i*8 +: 8] = 8'h00;
            req_last[i] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int k;
    int base;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_trmt", 32'(trmt), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // single byte
    @(posedge clk); #1;
    push_src(0, 8'hA5, 1'b1);
    expect_byte(0, 8'hA5, 1'b0);
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (!trmt && k < 10);
    chk("s1_latency", 32'(k), 32'd2);
    @(negedge clk); #1;
    chk("s1_ack_pulse", 32'(ack), 32'd0);
    chk("s1_trmt_pulse", 32'(trmt), 32'd0);
    k = 0;
    while (!tx_done && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    chk("s1_busy_at_done", 32'(busy), 32'd1);
    @(negedge clk); #1;
    chk("s1_busy_after", 32'(busy), 32'd0);
    wait_idle("s1_idle");

    // fairness: every requester holds two single-byte packets, last winner was 0
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++) push_src(i, 8'h10 + 8'(i), 1'b1);
    for (int r = 0; r < 2; r++)
      for (int j = 1; j <= NUM_REQ; j++)
        expect_byte(j % NUM_REQ, 8'h10 + 8'(j % NUM_REQ), !(r == 0 && j == 1));
    wait_idle("s2_idle");

    // packet lock: three-byte packet from 1 while 2 waits
    base = n_trmt;
    @(posedge clk); #1;
    push_src(1, 8'h21, 1'b0);
    push_src(1, 8'h22, 1'b0);
    push_src(1, 8'h23, 1'b1);
    push_src(2, 8'h2A, 1'b1);
    expect_byte(1, 8'h21, 1'b0);
    expect_byte(1, 8'h22, 1'b1);
    expect_byte(1, 8'h23, 1'b1);
    expect_byte(2, 8'h2A, 1'b1);
    wait_trmt(base + 1, "s3_first");
    repeat (10) @(negedge clk);
    #1;
    chk("s3_grant_held", 32'(grant), 32'h2);
    chk("s3_busy", 32'(busy), 32'd1);
    wait_idle("s3_idle");

    // locked owner stall: 1 drops after the first byte of two while 3 waits
    base = n_trmt;
    @(posedge clk); #1;
    push_src(1, 8'h31, 1'b0);
    expect_byte(1, 8'h31, 1'b0);
    wait_trmt(base + 1, "s4_first");
    @(posedge clk); #1;
    push_src(3, 8'h3A, 1'b1);
    repeat (3 * FRAME) @(negedge clk);
    #1;
    chk("s4_no_trmt", 32'(n_trmt), 32'(base + 1));
    chk("s4_busy", 32'(busy), 32'd1);
    chk("s4_grant", 32'(grant), 32'h2);
    @(posedge clk); #1;
    push_src(1, 8'h32, 1'b1);
    expect_byte(1, 8'h32, 1'b0);
    expect_byte(3, 8'h3A, 1'b1);
    wait_idle("s4_idle");

    // reset mid-byte, then rr_ptr must be back at NUM_REQ-1
    base = n_trmt;
    @(posedge clk); #1;
    push_src(1, 8'h41, 1'b1);
    expect_byte(1, 8'h41, 1'b0);
    wait_trmt(base + 1, "s5_first");
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("s5_trmt", 32'(trmt), 32'd0);
    chk("s5_grant", 32'(grant), 32'd0);
    chk("s5_ack", 32'(ack), 32'd0);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_tx_data", 32'(tx_data), 32'd0);
    @(posedge clk); #1;
    push_src(2, 8'h52, 1'b1);
    push_src(0, 8'h50, 1'b1);
    expect_byte(0, 8'h50, 1'b0);
    expect_byte(2, 8'h52, 1'b1);
    wait_idle("s5_idle");

    chk("ack_vs_trmt", 32'(n_ack), 32'(n_trmt));
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
